// File: rtl/alu_seq_core.sv
// Registered ALU core: SUB, NAND, iterative leading-ones count and one-hot decode.
// Define ALU_SEQ_ONEHOT_EN to build the one-hot scan; otherwise op 11 reports an error.
module alu_seq_core #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(2*WIDTH+1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_overflow,
    output logic             o_err,
    output logic [1:0]       o_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid must not depend on ready, and ready here is simply IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SUB    = 2'b00;
    localparam logic [1:0] OP_NAND   = 2'b01;
    localparam logic [1:0] OP_LEAD   = 2'b10;
    localparam int         SCAN_W    = 2*WIDTH;
    localparam int         MSB       = WIDTH-1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SCAN_W-1);
    localparam logic [63:0] Y_MAX    = (64'd1 << WIDTH) - 64'd1;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    y_q, y_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    diff;
    logic                lead_bit;
    logic [CNT_W-1:0]    cnt_inc;
`ifdef ALU_SEQ_ONEHOT_EN
    logic                found_q, found_d;
    logic                multi_q, multi_d;
    logic                oh_bit;
    logic                found_nxt;
    logic                multi_nxt;
    logic [CNT_W-1:0]    pos_nxt;
`endif

    assign diff       = i_a - i_b;
    assign o_ready    = (state_q == S_IDLE);
    assign o_valid    = (state_q == S_DONE);
    assign o_y        = y_q;
    assign o_overflow = ovf_q;
    assign o_err      = err_q;
    assign o_state    = state_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        scan_d   = scan_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        lead_bit = scan_q[SCAN_W-1];
        cnt_inc  = cnt_q + CNT_W'(lead_bit);
`ifdef ALU_SEQ_ONEHOT_EN
        found_d   = found_q;
        multi_d   = multi_q;
        oh_bit    = scan_q[0];
        found_nxt = found_q | oh_bit;
        multi_nxt = multi_q | (found_q & oh_bit);
        pos_nxt   = (oh_bit && !found_q) ? idx_q : cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    op_d = i_op;
                    case (i_op)
                        OP_SUB: begin
                            y_d     = diff;
                            ovf_d   = (i_a[MSB] != i_b[MSB]) && (i_a[MSB] != diff[MSB]);
                            err_d   = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_NAND: begin
                            y_d     = ~(i_a & i_b);
                            ovf_d   = 1'b0;
                            err_d   = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_LEAD: begin
                            scan_d  = {i_b, i_a};
                            idx_d   = '0;
                            cnt_d   = '0;
                            state_d = S_CALC;
                        end
                        default: begin
`ifdef ALU_SEQ_ONEHOT_EN
                            scan_d  = {i_b, i_a};
                            idx_d   = '0;
                            cnt_d   = '0;
                            found_d = 1'b0;
                            multi_d = 1'b0;
                            state_d = S_CALC;
`else
                            y_d     = '0;
                            ovf_d   = 1'b0;
                            err_d   = 1'b1;
                            state_d = S_DONE;
`endif
                        end
                    endcase
                end
            end
            S_CALC: begin
                idx_d = idx_q + CNT_W'(1);
                if (op_q == OP_LEAD) begin
                    // MSB-first: stop at the first zero or after the last bit
                    scan_d = scan_q << 1;
                    cnt_d  = cnt_inc;
                    if (!lead_bit || idx_q == LAST_IDX) begin
                        y_d     = WIDTH'(cnt_inc);
                        ovf_d   = 64'(cnt_inc) > Y_MAX;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
`ifdef ALU_SEQ_ONEHOT_EN
                    // LSB-first over every bit; cnt holds the first-one index
                    scan_d  = scan_q >> 1;
                    found_d = found_nxt;
                    multi_d = multi_nxt;
                    cnt_d   = pos_nxt;
                    if (idx_q == LAST_IDX) begin
                        y_d     = found_nxt ? WIDTH'(pos_nxt) : '0;
                        ovf_d   = found_nxt && (64'(pos_nxt) > Y_MAX);
                        err_d   = !found_nxt || multi_nxt;
                        state_d = S_DONE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_DONE: begin
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_ONEHOT_EN
            found_q <= 1'b0;
            multi_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_ONEHOT_EN
            found_q <= found_d;
            multi_q <= multi_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: directed vectors, expected results queued at
// issue and checked by an independent monitor on each presented result.
module tb_alu_seq_core;

    logic       clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_op;
    logic [3:0] i_a;
    logic [3:0] i_b;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_y;
    logic       o_overflow;
    logic       o_err;
    logic [1:0] dbg_state;

    logic       v2, rdy2, ov2, ovf2, err2;
    logic [1:0] op2, a2, b2, y2, st2;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int acc_cyc      = 0;
    int lat_meas     = 0;
    bit seen         = 0;
    logic [3:0] hold_y;
    logic [1:0] hold_flags;

    // {latency[7:0], err, overflow, y[3:0]}
    logic [13:0] exp_q[$];

    alu_seq_core #(.WIDTH(4)) u_dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_y(o_y), .o_overflow(o_overflow), .o_err(o_err), .o_state(dbg_state)
    );

    alu_seq_core #(.WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(v2), .o_ready(rdy2),
        .i_op(op2), .i_a(a2), .i_b(b2), .o_valid(ov2), .i_ready(1'b1),
        .o_y(y2), .o_overflow(ovf2), .o_err(err2), .o_state(st2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!i_rst_n) begin
            seen = 0;
        end else if (o_valid) begin
            if (!seen) begin
                seen       = 1;
                lat_meas   = cyc - acc_cyc + 1;
                hold_y     = o_y;
                hold_flags = {o_overflow, o_err};
            end else begin
                chk("hold_y", o_y, hold_y);
                chk("hold_flags", {o_overflow, o_err}, hold_flags);
                chk("ready_in_done", o_ready, 1'b0);
            end
            if (i_ready) begin
                logic [13:0] e;
                seen = 0;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_result: got o_y=%0h with no expected entry", o_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", o_y, e[3:0]);
                    chk("overflow", o_overflow, e[4]);
                    chk("err", o_err, e[5]);
                    chk("latency", lat_meas, e[13:6]);
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input bit push, input logic [3:0] y, input logic ovf,
                        input logic err, input int lat);
        if (push) exp_q.push_back({8'(lat), err, ovf, y});
        @(negedge clk);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        i_valid = 1'b0;
        i_a     = ~a;
        i_b     = ~b;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_valid(input logic [1:0] op);
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_op    = op;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    initial begin
        int n;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_op    = '0;
        i_a     = '0;
        i_b     = '0;
        i_ready = 1'b1;
        v2      = 1'b0;
        op2     = '0;
        a2      = '0;
        b2      = '0;

        #12;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_y", o_y, 4'h0);
        chk("rst_flags", {o_overflow, o_err}, 2'b00);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        send(2'b00, 4'b0111, 4'b1111, 1, 4'b1000, 1, 0, 1); wait_done();
        send(2'b00, 4'b0011, 4'b0001, 1, 4'b0010, 0, 0, 1); wait_done();
        send(2'b00, 4'b1000, 4'b0001, 1, 4'b0111, 1, 0, 1); wait_done();
        send(2'b01, 4'b1100, 4'b1010, 1, 4'b0111, 0, 0, 1); wait_done();
        send(2'b01, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 1); wait_done();
        send(2'b10, 4'b1100, 4'b1111, 1, 4'b0110, 0, 0, 8); wait_done();
        send(2'b10, 4'b1111, 4'b0111, 1, 4'b0000, 0, 0, 2); wait_done();
        send(2'b10, 4'b1111, 4'b1111, 1, 4'b1000, 0, 0, 9); wait_done();
`ifdef ALU_SEQ_ONEHOT_EN
        send(2'b11, 4'b0000, 4'b0100, 1, 4'b0110, 0, 0, 9); wait_done();
        send(2'b11, 4'b0001, 4'b0100, 1, 4'b0000, 0, 1, 9); wait_done();
        send(2'b11, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 9); wait_done();
`else
        send(2'b11, 4'b0000, 4'b0100, 1, 4'b0000, 0, 1, 1); wait_done();
        send(2'b11, 4'b0001, 4'b0100, 1, 4'b0000, 0, 1, 1); wait_done();
        send(2'b11, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 1); wait_done();
`endif

        // backpressure in DONE with a stray request
        i_ready = 1'b0;
        send(2'b00, 4'b0101, 4'b0011, 1, 4'b0010, 0, 0, 1);
        pulse_valid(2'b01);
        @(posedge clk); #1;
        i_ready = 1'b1;
        wait_done();

        // stray requests while scanning
        send(2'b10, 4'b1111, 4'b1111, 1, 4'b1000, 0, 0, 9);
        pulse_valid(2'b00);
        @(posedge clk);
        pulse_valid(2'b01);
        wait_done();

        // reset during a scan
        send(2'b00, 4'b1000, 4'b0001, 1, 4'b0111, 1, 0, 1); wait_done();
        send(2'b10, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_ready", o_ready, 1'b1);
        chk("midrst_y", o_y, 4'h0);
        chk("midrst_flags", {o_overflow, o_err}, 2'b00);
        @(negedge clk);
        i_rst_n = 1'b1;
        send(2'b00, 4'b0111, 4'b0010, 1, 4'b0101, 0, 0, 1); wait_done();

        // WIDTH=2 all-ones leading count
        @(negedge clk);
        v2  = 1'b1;
        op2 = 2'b10;
        a2  = 2'b11;
        b2  = 2'b11;
        @(posedge clk); #1;
        v2 = 1'b0;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov2 && n < 50);
        chk("w2_latency", n, 5);
        chk("w2_y", y2, 2'b00);
        chk("w2_overflow", ovf2, 1'b1);
        chk("w2_err", err2, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Sequential, parametrised successor to the combinational ALU library blocks. It performs subtract, NAND, leading-ones count and one-hot decode. Operands are accepted through a valid/ready handshake. The two bit-scan operations run iteratively, one bit per clock. Results are held in output registers until downstream accepts them. It sits between the operand/opcode source and the result consumer, and replaces per-operation combinational instances with a single registered core.

## Interface
- `WIDTH`, 4: operand and result width in bits; must be ≥ 2.
- `CNT_W`, `$clog2(2*WIDTH+1)`: internal counter/position width; derived, never overridden.

Ports:
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: operand/opcode valid.
- `o_ready` out 1: core can accept; equals (state == IDLE).
- `i_op` in 2: 00 SUB, 01 NAND, 10 LEAD_ONES, 11 ONEHOT.
- `i_a` in WIDTH: operand A, signed for SUB.
- `i_b` in WIDTH: operand B, signed for SUB.
- `o_valid` out 1: result valid; high in DONE.
- `i_ready` in 1: downstream accepts the result.
- `o_y` out WIDTH: result.
- `o_overflow` out 1: overflow flag.
- `o_err` out 1: error flag.

## Operation
- States: IDLE, CALC, DONE.
- Accept: on the edge where `i_valid && o_ready` is true, latch `i_op`, `i_a` and `i_b`. Input changes after that edge are ignored.
  - SUB/NAND: compute and go to DONE.
  - LEAD_ONES/ONEHOT: load scan vector {B,A}, clear the counter and flags, go to CALC.
- SUB: `o_y = A - B`, truncated to WIDTH. `o_overflow = (A[MSB] != B[MSB]) && (A[MSB] != o_y[MSB])`. `o_err = 0`.
- NAND: `o_y = ~(A & B)`. `o_overflow = 0`, `o_err = 0`.
- LEAD_ONES: scan {B,A} from bit 2W-1 downward, one bit per clock.
  - A 1 increments the count.
  - The first 0, or examining bit 0, ends the scan and moves to DONE.
  - `o_y = count[WIDTH-1:0]`; `o_overflow = (count > 2^WIDTH-1)`; `o_err = 0`.
- ONEHOT: scan {B,A} from bit 0 upward, one bit per clock, always all 2W bits.
  - Record the index of the first 1.
  - `o_err = 1` if zero bits or more than one bit are set.
  - `o_y = pos[WIDTH-1:0]`, or 0 if there are no ones; `o_overflow = (pos > 2^WIDTH-1)`.
- DONE: outputs held stable while `i_ready = 0`. On the edge where `o_valid && i_ready`, go to IDLE. `o_y` and flags keep their values until the next result is written.
- `i_valid` outside IDLE is ignored, with no queuing.

## Timing
- Reset (async, immediate):
  - state IDLE, `o_valid = 0`, `o_ready = 1`.
  - `o_y = 0`, `o_overflow = 0`, `o_err = 0`.
  - counter and scan registers cleared.
- Reset asserted mid-CALC or in DONE aborts the operation; the result is lost and never presented.
- Latency, measured from the accept edge to the edge where `o_valid` rises:
  - SUB/NAND: 1.
  - LEAD_ONES: 1 + min(count+1, 2W).
  - ONEHOT: 1 + 2W.
- Minimum issue interval: latency + 1. IDLE is re-entered after the handshake edge, and the next accept happens on the following edge.
- Boundary: LEAD_ONES with all ones takes 1 + 2W cycles; count = 2W.

## Configuration
- `ALU_SEQ_ONEHOT_EN` defined: ONEHOT implemented as above.
- Not defined: ONEHOT logic is not compiled. Op 11 goes straight to DONE with latency 1, `o_y = 0`, `o_err = 1`, `o_overflow = 0`.

## Test plan
- SUB, WIDTH=4, A=0111, B=1111 (7 − (−1)) → `o_y = 1000`, `o_overflow = 1`, `o_err = 0`; `o_valid` 1 cycle after accept. Also A=0011, B=0001 → `o_y = 0010`, `o_overflow = 0`.
- NAND, A=1100, B=1010 → `o_y = 0111`, latency 1. Then LEAD_ONES, B=1111, A=1100 → `o_y = 0110`, latency 8.
- LEAD_ONES all ones:
  - WIDTH=4, B=A=1111 → `o_y = 1000`, `o_overflow = 0`, latency 9.
  - WIDTH=2, B=A=11 → count 4, `o_y = 00`, `o_overflow = 1`, latency 5.
- ONEHOT, WIDTH=4 (with `ALU_SEQ_ONEHOT_EN`):
  - B=0100, A=0000 → `o_y = 0110`, `o_err = 0`, latency 9.
  - B=0100, A=0001 → `o_err = 1`.
  - B=A=0 → `o_y = 0`, `o_err = 1`.
  - Without the macro: op 11 → `o_err = 1`, latency 1.
- Backpressure: hold `i_ready = 0` for 3 cycles in DONE → `o_valid`, `o_y` and flags stable, `o_ready = 0`. `i_valid` pulses during CALC/DONE are ignored, with no extra result.
- Reset mid-CALC of LEAD_ONES → outputs zero immediately, `o_ready = 1`. After release, a new SUB is accepted and yields the correct result with latency 1.
